// File: rtl/serial_slave_mem_if.sv
// Serial bus lines between a bus master and serial_slave_mem: control frame,
// write data stream and the slave's read/flow-control responses.
interface serial_slave_mem_if;
   logic control;
   logic wD;
   logic valid;
   logic last;
   logic rD;
   logic rdValid;
   logic ready;
   logic busy;
   logic errFlag;

   modport master (
      output control, wD, valid, last,
      input  rD, rdValid, ready, busy, errFlag
   );

   modport slave (
      input  control, wD, valid, last,
      output rD, rdValid, ready, busy, errFlag
   );
endinterface

// File: rtl/serial_slave_mem.sv
// Serial-bus slave with internal word memory: decodes control frames and serves
// single/burst writes and reads. Optional frame parity: SERIAL_SLAVE_PARITY_EN.
module serial_slave_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_DEPTH = 4096,
   parameter int SID_W      = 2,
   parameter int SLAVEID    = 1,
   parameter int RD_DELAY   = 5,
   parameter int WR_WAIT    = 2
) (
   input  logic              clk,
   input  logic              rstN,
   serial_slave_mem_if.slave bus
);
   localparam int ADDR_W = $clog2(ADDR_DEPTH);
`ifdef SERIAL_SLAVE_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int FIELD_W   = SID_W + 2 + ADDR_W + PAR_W;
   localparam int FRAME_LEN = 3 + FIELD_W;
   localparam int MAX_A     = (FRAME_LEN > DATA_WIDTH) ? FRAME_LEN : DATA_WIDTH;
   localparam int MAX_B     = (RD_DELAY > WR_WAIT) ? RD_DELAY : WR_WAIT;
   localparam int MAX_CNT   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W     = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] WORD_END  = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] LAT_END   = CNT_W'(RD_DELAY - 1);
   localparam logic [CNT_W-1:0] WAIT_END  = CNT_W'(WR_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CTRL, S_WR_DATA, S_WR_WAIT, S_RD_LAT, S_RD_DATA
   } state_t;

   state_t state, state_d;

   logic [FIELD_W-2:0]    field_sr;
   logic [FIELD_W-1:0]    field_full;
   logic [SID_W-1:0]      frame_id;
   logic                  frame_rdwr;
   logic                  frame_burst;
   logic [ADDR_W-1:0]     frame_addr;
   logic                  par_err;
   logic                  err_q;

   logic [ADDR_W-1:0]     ptr;
   logic [ADDR_W-1:0]     ptr_inc;
   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-2:0] wr_sr;
   logic [DATA_WIDTH-1:0] wr_word;
   logic [DATA_WIDTH-1:0] rd_sr;
   logic                  burst_q;
   logic                  last_seen;
   logic                  xfer_done;

   logic                  frame_end;
   logic                  start_bad;
   logic                  id_ok;
   logic                  word_end;
   logic                  stop_req;
   logic                  mem_we;

   logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];

   // Fields are taken straight off the shift path so the decision is made on the final frame bit.
   assign field_full  = {field_sr, bus.control};
   assign frame_addr  = field_full[PAR_W +: ADDR_W];
   assign frame_burst = field_full[PAR_W + ADDR_W];
   assign frame_rdwr  = field_full[PAR_W + ADDR_W + 1];
   assign frame_id    = field_full[FIELD_W-1 -: SID_W];
   assign id_ok       = (frame_id == SID_W'(SLAVEID));

   assign frame_end = (state == S_CTRL) && (cnt == FRAME_END);
   assign start_bad = (state == S_CTRL) && (cnt < CNT_W'(3)) && !bus.control;
   assign word_end  = (cnt == WORD_END);
   assign stop_req  = !burst_q || last_seen || bus.last;
   assign mem_we    = (state == S_WR_DATA) && bus.valid && word_end;
   assign wr_word   = {wr_sr, bus.wD};
   assign ptr_inc   = (ptr == ADDR_W'(ADDR_DEPTH - 1)) ? '0 : ptr + 1'b1;

`ifdef SERIAL_SLAVE_PARITY_EN
   // Even parity: the XOR of all fields plus the parity bit must be zero.
   assign par_err = ^field_full;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) err_q <= 1'b0;
      else       err_q <= frame_end && par_err;
   end
`else
   assign par_err = 1'b0;
   assign err_q   = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) state <= S_IDLE;
      else       state <= state_d;
   end

   // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state;
      unique case (state)
         S_IDLE:    if (bus.control) state_d = S_CTRL;
         S_CTRL: begin
            if (start_bad || (frame_end && (par_err || !id_ok))) state_d = S_IDLE;
            else if (frame_end) state_d = frame_rdwr ? S_WR_DATA : S_RD_LAT;
         end
         S_WR_DATA: begin
            if (mem_we) begin
               if (WR_WAIT > 0)   state_d = S_WR_WAIT;
               else if (stop_req) state_d = S_IDLE;
            end
         end
         S_WR_WAIT: if (cnt == WAIT_END) state_d = xfer_done ? S_IDLE : S_WR_DATA;
         S_RD_LAT:  if (cnt == LAT_END)  state_d = S_RD_DATA;
         S_RD_DATA: if (word_end)        state_d = stop_req ? S_IDLE : S_RD_LAT;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ready   = 1'b1;
      bus.busy    = (state != S_IDLE);
      bus.rdValid = 1'b0;
      bus.rD      = 1'b0;
      bus.errFlag = err_q;
      case (state)
         S_WR_WAIT, S_RD_LAT: bus.ready = 1'b0;
         S_RD_DATA: begin
            bus.ready   = 1'b0;
            bus.rdValid = 1'b1;
            bus.rD      = rd_sr[DATA_WIDTH-1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         field_sr  <= '0;
         ptr       <= '0;
         cnt       <= '0;
         wr_sr     <= '0;
         rd_sr     <= '0;
         burst_q   <= 1'b0;
         last_seen <= 1'b0;
         xfer_done <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               cnt       <= bus.control ? CNT_W'(1) : '0;
               last_seen <= 1'b0;
               xfer_done <= 1'b0;
            end
            S_CTRL: begin
               field_sr <= field_full[FIELD_W-2:0];
               cnt      <= cnt + 1'b1;
               if (frame_end) begin
                  cnt     <= '0;
                  ptr     <= frame_addr;
                  burst_q <= frame_burst;
               end
            end
            S_WR_DATA: begin
               if (bus.valid) begin
                  wr_sr <= wr_word[DATA_WIDTH-2:0];
                  cnt   <= cnt + 1'b1;
                  if (bus.last) last_seen <= 1'b1;
                  if (word_end) begin
                     cnt       <= '0;
                     ptr       <= ptr_inc;
                     xfer_done <= stop_req;
                  end
               end
            end
            S_WR_WAIT: cnt <= (cnt == WAIT_END) ? '0 : cnt + 1'b1;
            S_RD_LAT: begin
               if (bus.last) last_seen <= 1'b1;
               cnt <= cnt + 1'b1;
               if (cnt == LAT_END) begin
                  cnt   <= '0;
                  rd_sr <= mem[ptr];
               end
            end
            S_RD_DATA: begin
               if (bus.last) last_seen <= 1'b1;
               rd_sr <= {rd_sr[DATA_WIDTH-2:0], 1'b0};
               cnt   <= cnt + 1'b1;
               if (word_end) begin
                  cnt <= '0;
                  ptr <= ptr_inc;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; contents survive rstN and map to RAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem[ptr] <= wr_word;
   end

endmodule

// File: tb/tb_serial_slave_mem.sv
// Directed self-checking bench for serial_slave_mem at default parameters
// (8-bit words, 4096 words, id 1, read latency 5, write wait 2).
module tb_serial_slave_mem;
   localparam int AW = 12;

   logic clk  = 1'b0;
   logic rstN = 1'b0;
   int   total = 0;
   int   bad   = 0;

   serial_slave_mem_if bus ();

   serial_slave_mem dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance to the next falling edge and return all master lines to idle.
   task automatic step();
      @(negedge clk);
      bus.control = 1'b0;
      bus.valid   = 1'b0;
      bus.last    = 1'b0;
      bus.wD      = 1'b0;
   endtask

   task automatic send_frame(input logic [1:0] id, input logic rdwr, input logic burst,
                             input logic [AW-1:0] addr);
      logic [AW+6:0] bits;
      bits = {3'b111, id, rdwr, burst, addr};
      for (int i = AW + 6; i >= 0; i--) begin
         step();
         bus.control = bits[i];
      end
`ifdef SERIAL_SLAVE_PARITY_EN
      step();
      bus.control = ^{id, rdwr, burst, addr};
`endif
   endtask

   task automatic write_bit(input logic b, input logic l);
      int n = 0;
      step();
      while (!bus.ready && n < 50) begin
         step();
         n++;
      end
      if (!bus.ready) begin
         total++;
         bad++;
         $display("FAIL write_ready_timeout: ready=%b after %0d cycles, required 1", bus.ready, n);
      end
      bus.valid = 1'b1;
      bus.wD    = b;
      bus.last  = l;
   endtask

   task automatic write_word(input logic [7:0] d, input logic last_on_final);
      for (int i = 7; i >= 0; i--) write_bit(d[i], last_on_final && (i == 0));
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy && n < 100) begin
         step();
         n++;
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s: busy=%b after %0d cycles, required 0", name, bus.busy, n);
      end
   endtask

   task automatic write_single(input logic [AW-1:0] addr, input logic [7:0] d);
      send_frame(2'd1, 1'b1, 1'b0, addr);
      write_word(d, 1'b0);
      wait_idle("write_single_idle");
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      repeat (2) step();
      total++;
      if ({bus.ready, bus.busy, bus.rdValid, bus.rD, bus.errFlag} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_outputs: {ready,busy,rdValid,rD,errFlag}=%b, required 10000",
                  {bus.ready, bus.busy, bus.rdValid, bus.rD, bus.errFlag});
      end
      step();
      rstN = 1'b1;
      step();
   endtask

   task automatic preload();
      write_single(12'd1, 8'h5C);
      write_single(12'd2, 8'h12);
      write_single(12'd4, 8'h34);
      write_single(12'd5, 8'h5A);
      write_single(12'd11, 8'hC3);
   endtask

   task automatic test_single_write();
      send_frame(2'd1, 1'b1, 1'b0, 12'd3);
      write_word(8'hA5, 1'b0);
      step();
      total++;
      if ({bus.ready, bus.busy} !== 2'b01) begin
         bad++;
         $display("FAIL sw_wait1: {ready,busy}=%b, required 01", {bus.ready, bus.busy});
      end
      total++;
      if (dut.mem[3] !== 8'hA5) begin
         bad++;
         $display("FAIL sw_mem3: got %h, required a5", dut.mem[3]);
      end
      step();
      total++;
      if ({bus.ready, bus.busy} !== 2'b01) begin
         bad++;
         $display("FAIL sw_wait2: {ready,busy}=%b, required 01", {bus.ready, bus.busy});
      end
      step();
      total++;
      if ({bus.ready, bus.busy} !== 2'b10) begin
         bad++;
         $display("FAIL sw_done: {ready,busy}=%b, required 10", {bus.ready, bus.busy});
      end
      total++;
      if ({dut.mem[2], dut.mem[4]} !== 16'h1234) begin
         bad++;
         $display("FAIL sw_neighbours: mem2,mem4=%h, required 1234", {dut.mem[2], dut.mem[4]});
      end
   endtask

   task automatic test_burst_wrap();
      send_frame(2'd1, 1'b1, 1'b1, 12'd4094);
      write_word(8'h11, 1'b0);
      write_word(8'h22, 1'b0);
      write_word(8'h33, 1'b1);
      wait_idle("bw_idle");
      total++;
      if ({dut.mem[4094], dut.mem[4095], dut.mem[0]} !== 24'h112233) begin
         bad++;
         $display("FAIL bw_data: mem4094,4095,0=%h, required 112233",
                  {dut.mem[4094], dut.mem[4095], dut.mem[0]});
      end
      total++;
      if (dut.mem[1] !== 8'h5C) begin
         bad++;
         $display("FAIL bw_stop: mem1=%h, required 5c", dut.mem[1]);
      end
   endtask

   task automatic test_read_latency();
      logic [7:0] exp_word;
      exp_word = 8'hA5;
      send_frame(2'd1, 1'b0, 1'b0, 12'd3);
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if (bus.rdValid !== 1'b0) begin
            bad++;
            $display("FAIL rd_latency_c%0d: rdValid=%b, required 0", i + 1, bus.rdValid);
         end
      end
      for (int i = 7; i >= 0; i--) begin
         step();
         total++;
         if ({bus.rdValid, bus.rD} !== {1'b1, exp_word[i]}) begin
            bad++;
            $display("FAIL rd_bit%0d: {rdValid,rD}=%b, required %b", i,
                     {bus.rdValid, bus.rD}, {1'b1, exp_word[i]});
         end
      end
      step();
      total++;
      if ({bus.rdValid, bus.busy, bus.ready} !== 3'b001) begin
         bad++;
         $display("FAIL rd_done: {rdValid,busy,ready}=%b, required 001",
                  {bus.rdValid, bus.busy, bus.ready});
      end
   endtask

   task automatic test_burst_read();
      logic [15:0] rx;
      int got = 0;
      bit sent_last = 1'b0;
      rx = '0;
      send_frame(2'd1, 1'b0, 1'b1, 12'd4095);
      for (int i = 0; i < 80; i++) begin
         step();
         if (bus.rdValid) begin
            rx = {rx[14:0], bus.rD};
            got++;
         end else if (got == 8 && !sent_last) begin
            bus.last  = 1'b1;
            sent_last = 1'b1;
         end
         if (!bus.busy) break;
      end
      total++;
      if (got !== 16) begin
         bad++;
         $display("FAIL br_count: got %0d bits, required 16", got);
      end
      total++;
      if (rx !== 16'h2233) begin
         bad++;
         $display("FAIL br_data: got %h, required 2233", rx);
      end
      wait_idle("br_idle");
   endtask

   task automatic test_id_mismatch();
      logic rdy_all  = 1'b1;
      logic rv_any   = 1'b0;
      logic busy_any = 1'b0;
      send_frame(2'd2, 1'b1, 1'b0, 12'd5);
      for (int i = 0; i < 8; i++) begin
         step();
         rdy_all  &= bus.ready;
         rv_any   |= bus.rdValid;
         busy_any |= bus.busy;
         bus.valid = 1'b1;
         bus.wD    = 1'b1;
      end
      repeat (3) begin
         step();
         rdy_all &= bus.ready;
         rv_any  |= bus.rdValid;
      end
      total++;
      if ({rdy_all, rv_any, busy_any} !== 3'b100) begin
         bad++;
         $display("FAIL idm_outputs: {ready_all,rdValid_any,busy_any}=%b, required 100",
                  {rdy_all, rv_any, busy_any});
      end
      total++;
      if (dut.mem[5] !== 8'h5A) begin
         bad++;
         $display("FAIL idm_mem5: got %h, required 5a", dut.mem[5]);
      end
   endtask

   task automatic test_bad_start();
      step();
      bus.control = 1'b1;
      step();
      bus.control = 1'b1;
      step();
      total++;
      if (bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL bs_busy_in_frame: busy=%b, required 1", bus.busy);
      end
      bus.control = 1'b0;
      step();
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL bs_abort: busy=%b, required 0", bus.busy);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [7:0] w2;
      w2 = 8'h3C;
      send_frame(2'd1, 1'b1, 1'b1, 12'd10);
      write_word(8'h96, 1'b0);
      for (int i = 7; i >= 4; i--) write_bit(w2[i], 1'b0);
      #6;
      total++;
      if (bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL rm_busy_before: busy=%b, required 1", bus.busy);
      end
      rstN = 1'b0;
      #1;
      total++;
      if ({bus.ready, bus.busy, bus.rdValid, bus.rD, bus.errFlag} !== 5'b10000) begin
         bad++;
         $display("FAIL rm_async_outputs: {ready,busy,rdValid,rD,errFlag}=%b, required 10000",
                  {bus.ready, bus.busy, bus.rdValid, bus.rD, bus.errFlag});
      end
      step();
      rstN = 1'b1;
      total++;
      if ({dut.mem[10], dut.mem[11]} !== 16'h96C3) begin
         bad++;
         $display("FAIL rm_mem: mem10,mem11=%h, required 96c3", {dut.mem[10], dut.mem[11]});
      end
      write_single(12'd11, 8'h4B);
      total++;
      if (dut.mem[11] !== 8'h4B) begin
         bad++;
         $display("FAIL rm_recover: mem11=%h, required 4b", dut.mem[11]);
      end
   endtask

`ifdef SERIAL_SLAVE_PARITY_EN
   task automatic test_parity();
      logic [AW+7:0] bits;
      write_single(12'd20, 8'h77);
      bits    = {3'b111, 2'd1, 1'b1, 1'b0, 12'd20, 1'b0};
      bits[0] = ~(^bits[AW+4:1]);
      for (int i = AW + 7; i >= 0; i--) begin
         step();
         bus.control = bits[i];
      end
      step();
      total++;
      if ({bus.errFlag, bus.busy} !== 2'b10) begin
         bad++;
         $display("FAIL par_pulse: {errFlag,busy}=%b, required 10", {bus.errFlag, bus.busy});
      end
      bus.valid = 1'b1;
      for (int i = 1; i < 8; i++) begin
         step();
         bus.valid = 1'b1;
      end
      step();
      total++;
      if ({bus.errFlag, bus.busy} !== 2'b00) begin
         bad++;
         $display("FAIL par_after: {errFlag,busy}=%b, required 00", {bus.errFlag, bus.busy});
      end
      total++;
      if (dut.mem[20] !== 8'h77) begin
         bad++;
         $display("FAIL par_mem20: got %h, required 77", dut.mem[20]);
      end
   endtask
`endif

   initial begin
      bus.control = 1'b0;
      bus.valid   = 1'b0;
      bus.last    = 1'b0;
      bus.wD      = 1'b0;
      test_reset();
      preload();
      test_single_write();
      test_burst_wrap();
      test_read_latency();
      test_burst_read();
      test_id_mismatch();
      test_bad_start();
      test_reset_mid_burst();
`ifdef SERIAL_SLAVE_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_slave_mem.md
Name: serial_slave_mem

Overview:
- Parametrised next-generation serial-bus slave with an internal word memory.
- Decodes the serial control frame (start | id | R/W | burst | address) sent by the bus master.
- Serves single or burst writes on wD and reads on rD, with configurable data width, depth, id width, read latency and write wait states.
- Adds behaviour the first-generation slave lacks: address wrap-around, write back-pressure and a read-data qualifier.
- Sits behind the arbiter/bus on the master's serial lines.

Parameters:
- DATA_WIDTH, 8, bits per data word; serial order is MSB first.
- ADDR_DEPTH, 4096, number of memory words; ADDR_W = $clog2(ADDR_DEPTH).
- SID_W, 2, slave-id field width in the control frame.
- SLAVEID, 1, this slave's id; compared against the frame id field.
- RD_DELAY, 5, cycles from end of frame (or end of previous burst word) to first rD bit; minimum 1.
- WR_WAIT, 2, cycles ready is held low after each written word; 0 means no stall.

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- rstN  input  1  reset, asynchronous, active-low.
- control  input  1  serial control frame; idle 0.
- wD  input  1  serial write data.
- valid  input  1  qualifies wD bits.
- last  input  1  marks end of a burst.
- rD  output  1  serial read data.
- rdValid  output  1  qualifies rD bits.
- ready  output  1  slave can accept a write bit / is not busy; default high.
- busy  output  1  high from first start bit to end of transaction.
- errFlag  output  1  one-cycle pulse on frame error (optional feature only).

Behaviour:
- Reset (async, rstN=0): state IDLE; outputs ready=1, rD=0, rdValid=0, busy=0, errFlag=0; bit and word counters cleared. Memory contents are not cleared. Deassertion is synchronous to clk.
- Frame format: 3'b111, then SID_W id bits, then rdWr (1=write, 0=read), then burst, then ADDR_W address bits. All fields MSB first, one bit per cycle.
- IDLE: leave on the first control=1 sample. If fewer than 3 consecutive 1s follow, return to IDLE.
- CTRL: shift in the remaining fields; busy=1 from the first start bit.
- On id mismatch at the final frame bit, go to IDLE. No response is driven and memory is untouched.
- On id match, go to WR_DATA or RD_LAT and load the address pointer.
- WR_DATA:
  - Shift in wD on cycles with valid=1 and ready=1; bits with valid=1 and ready=0 are ignored.
  - On the DATA_WIDTH-th bit, write mem[ptr] that cycle.
  - ptr increments modulo ADDR_DEPTH, so 4095 wraps to 0.
  - If WR_WAIT>0, go to WR_WAIT.
- WR_WAIT: ready=0 for WR_WAIT cycles, then return to WR_DATA.
- Write termination: last is sampled only with valid=1. Non-burst ends after one word; last is ignored. Burst ends after the word whose final bit carried last=1.
  - last asserted mid-word: latched; the transaction ends when that word completes.
- RD_LAT: ready=0, count RD_DELAY cycles, then go to RD_DATA.
- RD_DATA: drive mem[ptr] MSB first on rD with rdValid=1 for DATA_WIDTH cycles. Then ptr increments with wrap.
  - Non-burst: done after one word.
  - Burst: continue if last has not been seen; reload the RD_DELAY latency before each word (via RD_LAT).
  - last=1 sampled in any RD_LAT/RD_DATA cycle: finish the current/next word, then done.
- Done: return to IDLE next cycle; ready=1, busy=0, rdValid=0, rD=0.
- control activity while not in IDLE/CTRL is ignored.
- Reset mid-transaction: abort immediately. A partial write word is discarded; completed words remain written.

Optional Feature:
- Macro: SERIAL_SLAVE_PARITY_EN.
- When defined:
  - One even-parity bit follows the address field; parity is computed over the id, rdWr, burst and address bits.
  - On mismatch, the frame is discarded (even if the id matches), errFlag pulses for one cycle, and the state goes to IDLE.
- When undefined: no parity bit in the frame and errFlag is tied to 0.

Test Plan:
1. Single write: id=01, rdWr=1, burst=0, addr=12'd3, wD=8'hA5 with valid → mem[3]=8'hA5; ready low 2 cycles after bit 8; busy falls; no other address changes.
2. Burst write with wrap: addr=12'd4094, words 8'h11, 8'h22, 8'h33, last on final bit → mem[4094]=11, mem[4095]=22, mem[0]=33.
3. Read latency: after test 1, frame read, burst=0, addr=3 → rdValid rises exactly 5 cycles after the last frame bit; rD=1,0,1,0,0,1,0,1 over 8 cycles; rdValid then falls.
4. Id mismatch: frame id=10, write addr=5, data 8'hFF → mem[5] unchanged; rdValid never asserted; ready stays high after the frame.
5. Reset mid-burst: rstN=0 after 4 bits of word 2 of a burst write at addr 10 → mem[10] written, mem[11] unchanged; all outputs at reset values asynchronously.
6. With SERIAL_SLAVE_PARITY_EN: matching-id frame with a flipped parity bit → errFlag one-cycle pulse; no write; state IDLE.
